ripple_count_capture: RTL and testbench

- Downstream consumer of the 4-bit up/down ripple counter. Its outputs settle asynchronously, bit by bit, relative to the system clock.
- Synchronises the raw count and accepts a value only once it is stable. Detects wrap-around to extend the count to a wider value.
- Presents each new extended count on a valid/ready output port. Flags step errors and output overruns.

---
 rtl/ripple_count_pkg.sv | 15 +
 rtl/ripple_count_capture_sync_stable_filter.sv | 47 ++++
 rtl/ripple_count_capture.sv | 135 +++++++++++++
 tb/tb_ripple_count_capture.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ripple_count_pkg.sv
// rtl/ripple_count_pkg.sv - shared types and constants for the ripple counter capture block
package ripple_count_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int Q_W = 4;
    localparam logic [Q_W-1:0] Q_MAX = 4'd15;

endpackage

// File: rtl/ripple_count_capture_sync_stable_filter.sv
// rtl/ripple_count_capture_sync_stable_filter.sv - 2-flop synchroniser with stability filter, one accept per stable period
module sync_stable_filter #(
    parameter int W             = 5,
    parameter int STABLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic         accept,
    output logic [W-1:0] value
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] ACC_AT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAT    = CNT_W'(STABLE_CYCLES);

    logic [W-1:0]     sync1;
    logic [W-1:0]     sync2;
    logic [CNT_W-1:0] stab_cnt;

    // Counter parks at SAT after accepting so a long stable period yields a single accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stab_cnt <= '0;
            accept   <= 1'b0;
            value    <= '0;
        end else begin
            sync1  <= d;
            sync2  <= sync1;
            accept <= 1'b0;
            if (sync1 != sync2) begin
                stab_cnt <= '0;
            end else begin
                if (stab_cnt == ACC_AT) begin
                    accept <= 1'b1;
                    value  <= sync2;
                end
                if (stab_cnt != SAT) begin
                    stab_cnt <= stab_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ripple_count_capture.sv
// rtl/ripple_count_capture.sv - captures a ripple counter value, extends it with a wrap count and presents it on valid/ready
module ripple_count_capture
    import ripple_count_pkg::*;
#(
    parameter int WRAP_W        = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            q_in,
    input  logic                  control,
    output logic [WRAP_W+3:0]     count_ext,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  wrap_up,
    output logic                  wrap_down,
    output logic                  step_err,
    output logic                  overrun
);

    logic           acc;
    logic [Q_W:0]   acc_val;
    logic           acc_dir;
    logic [Q_W-1:0] acc_q;

    // Direction travels with q so both are judged from the same stable sample.
    sync_stable_filter #(
        .W             (Q_W + 1),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .d      ({control, q_in}),
        .accept (acc),
        .value  (acc_val)
    );

    assign acc_dir = acc_val[Q_W];
    assign acc_q   = acc_val[Q_W-1:0];

    state_t            state, state_n;
    logic [Q_W-1:0]    last_q, last_q_n;
    logic [WRAP_W-1:0] wrap_hi, wrap_hi_n;
    logic [WRAP_W+3:0] count_ext_n;
    logic              out_valid_n, wrap_up_n, wrap_down_n, step_err_n, overrun_n;
    logic [Q_W-1:0]    step;
    logic              evt;

    always_comb begin
        state_n     = state;
        last_q_n    = last_q;
        wrap_hi_n   = wrap_hi;
        count_ext_n = count_ext;
        out_valid_n = out_valid;
        wrap_up_n   = 1'b0;
        wrap_down_n = 1'b0;
        step_err_n  = step_err;
        overrun_n   = overrun;
        step        = acc_q - last_q;
        evt         = 1'b0;

        case (state)
            INIT: begin
                if (acc) begin
                    state_n     = TRACK;
                    last_q_n    = acc_q;
                    wrap_hi_n   = '0;
                    count_ext_n = {{WRAP_W{1'b0}}, acc_q};
                end
            end
            TRACK: begin
                if (acc && (acc_q != last_q)) begin
                    evt      = 1'b1;
                    last_q_n = acc_q;
                    if (acc_dir == DIR_UP) begin
                        if (step == 4'd1) begin
                            if (last_q == Q_MAX) begin
                                wrap_hi_n = wrap_hi + WRAP_W'(1);
                                wrap_up_n = 1'b1;
                            end
                        end else begin
                            step_err_n = 1'b1;
                        end
                    end else begin
                        if (step == Q_MAX) begin
                            if (last_q == '0) begin
                                wrap_hi_n   = wrap_hi - WRAP_W'(1);
                                wrap_down_n = 1'b1;
                            end
                        end else begin
                            step_err_n = 1'b1;
                        end
                    end
                    count_ext_n = {wrap_hi_n, acc_q};
                end
            end
            default: state_n = INIT;
        endcase

        // A new value always wins; it is only an overrun if the old one was refused.
        if (evt) begin
            out_valid_n = 1'b1;
            if (out_valid && !out_ready) begin
                overrun_n = 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            last_q    <= '0;
            wrap_hi   <= '0;
            count_ext <= '0;
            out_valid <= 1'b0;
            wrap_up   <= 1'b0;
            wrap_down <= 1'b0;
            step_err  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            last_q    <= last_q_n;
            wrap_hi   <= wrap_hi_n;
            count_ext <= count_ext_n;
            out_valid <= out_valid_n;
            wrap_up   <= wrap_up_n;
            wrap_down <= wrap_down_n;
            step_err  <= step_err_n;
            overrun   <= overrun_n;
        end
    end

endmodule

// File: tb/tb_ripple_count_capture.sv
// tb/tb_ripple_count_capture.sv - randomized self-checking bench for ripple_count_capture
module tb_ripple_count_capture;

    localparam int WRAP_W        = 4;
    localparam int STABLE_CYCLES = 2;
    localparam int LAT           = 3 + STABLE_CYCLES;
    localparam int HOLD          = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] q_in;
    logic       control;
    logic [7:0] count_ext;
    logic       out_valid;
    logic       out_ready;
    logic       wrap_up;
    logic       wrap_down;
    logic       step_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // observations collected by apply()
    int ov_cnt, first_v, wu_cnt, wd_cnt;

    // reference model state
    int         mq, mwrap;
    logic       merr;
    logic       exp_chg, exp_wu, exp_wd;
    logic [7:0] exp_ext;

    ripple_count_capture #(
        .WRAP_W        (WRAP_W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .q_in      (q_in),
        .control   (control),
        .count_ext (count_ext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wrap_up   (wrap_up),
        .wrap_down (wrap_down),
        .step_err  (step_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic [3:0] nq, input logic dir);
        int d;
        exp_chg = (int'(nq) != mq);
        exp_wu  = 1'b0;
        exp_wd  = 1'b0;
        if (exp_chg) begin
            d = (int'(nq) - mq + 16) % 16;
            if (dir == 1'b0 && d == 1) begin
                if (mq == 15) begin
                    mwrap  = (mwrap + 1) % 16;
                    exp_wu = 1'b1;
                end
            end else if (dir == 1'b1 && d == 15) begin
                if (mq == 0) begin
                    mwrap  = (mwrap + 15) % 16;
                    exp_wd = 1'b1;
                end
            end else begin
                merr = 1'b1;
            end
            mq = int'(nq);
        end
        exp_ext = 8'(mwrap * 16 + mq);
    endtask

    task automatic apply(input logic [3:0] q, input logic dir, input int hold);
        q_in    = q;
        control = dir;
        ov_cnt  = 0;
        first_v = 0;
        wu_cnt  = 0;
        wd_cnt  = 0;
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                ov_cnt++;
                if (first_v == 0) first_v = i;
            end
            if (wrap_up)   wu_cnt++;
            if (wrap_down) wd_cnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; q_in = 4'd0; control = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({count_ext, out_valid, wrap_up, wrap_down, step_err, overrun} !== 13'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b%b want all zero", count_ext, out_valid, wrap_up, wrap_down, step_err, overrun);
        end
        rst = 1'b0;
        mq = 0; mwrap = 0; merr = 1'b0;
        apply(4'd0, 1'b0, HOLD);
        n_checks++;
        if (ov_cnt !== 0 || count_ext !== 8'h00) begin
            n_fail++;
            $display("FAIL init_absorb: valid_cycles=%0d count_ext=%h want 0 and 00", ov_cnt, count_ext);
        end
    endtask

    task automatic test_up_steps;
        for (int v = 1; v <= 2; v++) begin
            model_step(4'(v), 1'b0);
            apply(4'(v), 1'b0, HOLD);
            n_checks++;
            if (count_ext !== exp_ext) begin
                n_fail++;
                $display("FAIL up_count v=%0d: got %h want %h", v, count_ext, exp_ext);
            end
            n_checks++;
            if (ov_cnt !== 1 || first_v !== LAT) begin
                n_fail++;
                $display("FAIL up_latency v=%0d: valid_cycles=%0d first=%0d want 1 and %0d", v, ov_cnt, first_v, LAT);
            end
            n_checks++;
            if ({step_err, overrun, 1'(wu_cnt != 0), 1'(wd_cnt != 0)} !== 4'b0) begin
                n_fail++;
                $display("FAIL up_flags v=%0d: err=%b ovr=%b wu=%0d wd=%0d want none", v, step_err, overrun, wu_cnt, wd_cnt);
            end
        end
    endtask

    task automatic test_wrap;
        for (int v = 3; v <= 15; v++) begin
            model_step(4'(v), 1'b0);
            apply(4'(v), 1'b0, HOLD);
        end
        model_step(4'd0, 1'b0);
        apply(4'd0, 1'b0, HOLD);
        n_checks++;
        if (wu_cnt !== 1 || count_ext !== 8'h10) begin
            n_fail++;
            $display("FAIL wrap_up: pulses=%0d count_ext=%h want 1 and 10", wu_cnt, count_ext);
        end
        model_step(4'd15, 1'b1);
        apply(4'd15, 1'b1, HOLD);
        n_checks++;
        if (wd_cnt !== 1 || count_ext !== 8'h0F || step_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_down: pulses=%0d count_ext=%h err=%b want 1, 0f, 0", wd_cnt, count_ext, step_err);
        end
    endtask

    task automatic test_glitch_and_jump;
        for (int v = 14; v >= 3; v--) begin
            model_step(4'(v), 1'b1);
            apply(4'(v), 1'b1, HOLD);
        end
        model_step(4'd3, 1'b0);
        apply(4'd3, 1'b0, HOLD);
        n_checks++;
        if (ov_cnt !== 0) begin
            n_fail++;
            $display("FAIL dir_change_no_event: valid_cycles=%0d want 0", ov_cnt);
        end
        q_in = 4'd7;
        @(posedge clk);
        #1;
        model_step(4'd4, 1'b0);
        apply(4'd4, 1'b0, HOLD);
        n_checks++;
        if (count_ext !== 8'h04 || step_err !== 1'b0 || ov_cnt !== 1) begin
            n_fail++;
            $display("FAIL glitch: count_ext=%h err=%b valid_cycles=%0d want 04, 0, 1", count_ext, step_err, ov_cnt);
        end
        model_step(4'd9, 1'b0);
        apply(4'd9, 1'b0, HOLD);
        n_checks++;
        if (count_ext !== 8'h09 || step_err !== 1'b1) begin
            n_fail++;
            $display("FAIL jump: count_ext=%h err=%b want 09 and 1", count_ext, step_err);
        end
    endtask

    task automatic test_overrun;
        model_step(4'd5, 1'b0);
        apply(4'd5, 1'b0, HOLD);
        out_ready = 1'b0;
        model_step(4'd6, 1'b0);
        apply(4'd6, 1'b0, HOLD);
        n_checks++;
        if (out_valid !== 1'b1 || count_ext !== exp_ext || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_valid: valid=%b count_ext=%h ovr=%b want 1, %h, 0", out_valid, count_ext, overrun, exp_ext);
        end
        model_step(4'd7, 1'b0);
        apply(4'd7, 1'b0, HOLD);
        n_checks++;
        if (out_valid !== 1'b1 || count_ext !== 8'h07 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun: valid=%b count_ext=%h ovr=%b want 1, 07, 1", out_valid, count_ext, overrun);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_drain: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid;
        int cur = 7;
        repeat (41) begin
            cur = (cur + 1) % 16;
            model_step(4'(cur), 1'b0);
            apply(4'(cur), 1'b0, HOLD);
        end
        out_ready = 1'b0;
        model_step(4'd1, 1'b0);
        apply(4'd1, 1'b0, HOLD);
        n_checks++;
        if (count_ext !== 8'h31 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: count_ext=%h valid=%b want 31 and 1", count_ext, out_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({count_ext, out_valid, wrap_up, wrap_down, step_err, overrun} !== 13'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h/%b%b%b%b%b want all zero", count_ext, out_valid, wrap_up, wrap_down, step_err, overrun);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        mq = 1; mwrap = 0; merr = 1'b0;
        apply(4'd1, 1'b0, HOLD);
        n_checks++;
        if (ov_cnt !== 0 || count_ext !== 8'h01 || step_err !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_init: valid_cycles=%0d count_ext=%h err=%b ovr=%b want 0, 01, 0, 0", ov_cnt, count_ext, step_err, overrun);
        end
    endtask

    task automatic test_random;
        logic [3:0] nq;
        logic       dir;
        for (int k = 0; k < 40; k++) begin
            dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0)
                nq = dir ? 4'(mq - 1) : 4'(mq + 1);
            else
                nq = 4'($urandom_range(0, 15));
            model_step(nq, dir);
            apply(nq, dir, HOLD);
            n_checks++;
            if (count_ext !== exp_ext || step_err !== merr || overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_state k=%0d: count_ext=%h err=%b ovr=%b want %h, %b, 0", k, count_ext, step_err, overrun, exp_ext, merr);
            end
            n_checks++;
            if (ov_cnt !== (exp_chg ? 1 : 0) || (exp_chg && first_v !== LAT)) begin
                n_fail++;
                $display("FAIL rand_valid k=%0d: valid_cycles=%0d first=%0d want %0d at %0d", k, ov_cnt, first_v, exp_chg ? 1 : 0, LAT);
            end
            n_checks++;
            if (wu_cnt !== int'(exp_wu) || wd_cnt !== int'(exp_wd)) begin
                n_fail++;
                $display("FAIL rand_wrap k=%0d: wu=%0d wd=%0d want %0d, %0d", k, wu_cnt, wd_cnt, exp_wu, exp_wd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_steps();
        test_wrap();
        test_glitch_and_jump();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
